// File: rtl/mem_arbiter.sv
// Shares single-port main memory between I-cache refills and D-cache refills/stores.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate winner on ties instead of fixed D-cache priority.
module mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_gnt,
    output logic              ic_rvalid,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_gnt,
    output logic              dc_rvalid,
    output logic              dc_done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int LINE_B = $clog2(BURST_LEN * 4);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((64'd1 << LINE_B) - 64'd1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;   // 1 = D-cache owns the transfer
    logic              store_q, store_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic              pick_dc;
    logic              in_xfer, in_done, last_beat, rvalid_any;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_win_q, last_win_d;  // 1 = D-cache won the previous arbitration

    assign pick_dc = dc_req & (~ic_req | ~last_win_q);
`else
    assign pick_dc = dc_req;
`endif

    assign in_xfer   = (state_q == XFER);
    assign in_done   = (state_q == DONE);
    assign last_beat = store_q | (beat_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        store_d = store_q;
        base_d  = base_q;
        beat_d  = beat_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_win_d = last_win_q;
`endif
        case (state_q)
            IDLE: begin
                if (ic_req | dc_req) begin
                    state_d = XFER;
                    owner_d = pick_dc;
                    store_d = pick_dc & dc_we;
                    beat_d  = '0;
                    if (pick_dc)
                        base_d = dc_addr & (dc_we ? WORD_MASK : LINE_MASK);
                    else
                        base_d = ic_addr & LINE_MASK;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_win_d = pick_dc;
`endif
                end
            end
            XFER: begin
                if (mem_ready) begin
                    if (last_beat) state_d = DONE;
                    else           beat_d  = beat_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            store_q <= 1'b0;
            base_q  <= '0;
            beat_q  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_win_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            store_q <= store_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_win_q <= last_win_d;
`endif
        end
    end

    // Read data is passed straight through in the ready cycle; zero otherwise.
    assign rvalid_any = in_xfer & ~store_q & mem_ready;
    assign ic_gnt     = (in_xfer | in_done) & ~owner_q;
    assign dc_gnt     = (in_xfer | in_done) &  owner_q;
    assign ic_rvalid  = rvalid_any & ~owner_q;
    assign dc_rvalid  = rvalid_any &  owner_q;
    assign ic_done    = in_done & ~owner_q;
    assign dc_done    = in_done &  owner_q;
    assign rdata      = rvalid_any ? mem_rdata : '0;
    assign mem_en     = in_xfer;
    assign mem_we     = in_xfer & store_q;
    assign mem_addr   = in_xfer ? (base_q + (ADDR_W'(beat_q) << 2)) : '0;
    assign mem_wdata  = mem_we ? dc_wdata : '0;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port main memory between the instruction-cache and data-cache controllers.
- The I-cache issues line refills (burst reads). The D-cache issues line refills or single-word write-through stores.
- The block arbitrates, sequences the burst beats against a ready-handshaked memory, and returns data and completion pulses to the owning cache.
- It sits between both cache controllers and the memory model in the MIPS datapath.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width.
- BURST_LEN, 4, words per cache line refill; a power of 2 and >= 1.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- ic_req  in  1  I-cache refill request; held until ic_done.
- ic_addr  in  ADDR_W  I-cache miss address; stable while ic_req is high.
- ic_gnt  out  1  I-cache owns memory.
- ic_rvalid  out  1  rdata is valid for the I-cache this cycle.
- ic_done  out  1  one-cycle completion pulse to the I-cache.
- dc_req  in  1  D-cache request; held until dc_done.
- dc_we  in  1  1 = single-word store, 0 = line refill.
- dc_addr  in  ADDR_W  D-cache address; stable while dc_req is high.
- dc_wdata  in  DATA_W  store data; stable while dc_req is high.
- dc_gnt  out  1  D-cache owns memory.
- dc_rvalid  out  1  rdata is valid for the D-cache this cycle.
- dc_done  out  1  one-cycle completion pulse to the D-cache.
- rdata  out  DATA_W  shared read-return bus.
- mem_en  out  1  memory access request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address (byte address).
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ready is high.
- mem_ready  in  1  memory accepts/completes the current beat.

Behaviour:
- Reset:
  - Asynchronous on rst_n low: state = IDLE, beat counter = 0.
  - All outputs are 0, including rdata.
  - Reset mid-transfer abandons the transfer; no done pulse is issued.
- States: IDLE, XFER, DONE.
- IDLE:
  - Samples the requests each posedge.
  - If dc_req and ic_req are both high, the D-cache wins (fixed priority; see the optional feature).
  - On a winner, go to XFER and, at that edge, register:
    - owner;
    - base = addr with the low log2(BURST_LEN*4) bits cleared for refills, or the word-aligned addr for stores;
    - beats = 1 for stores, BURST_LEN for refills.
  - Grant latency: req high at edge N -> gnt, mem_en and mem_addr are all high/valid after edge N.
- XFER:
  - The owner's gnt is high.
  - mem_en = 1, mem_addr = base + 4*beat.
  - mem_we = 1 and mem_wdata = dc_wdata only for a D-cache store.
  - A beat completes on a posedge with mem_ready = 1; mem_addr and mem_en are held stable until then.
  - mem_ready while mem_en = 0 is ignored.
  - Refill beats:
    - In the cycle mem_ready = 1, the owner's rvalid = 1 and rdata = mem_rdata, combinationally passed.
    - Beat order is ascending from base, with no wrap or critical-word-first.
  - On the last completed beat, go to DONE; mem_en = 0 from the next cycle.
- DONE:
  - One cycle.
  - The owner's done = 1 and its gnt is still 1.
  - mem_en = 0.
  - Both req inputs are ignored.
  - Next state is IDLE.
- Requester contract: deassert req at the edge that ends DONE. A req still high in the following IDLE cycle is a new request.
- Back-to-back: minimum one IDLE cycle between transfers.
  - Refill of BURST_LEN beats with zero-wait memory: req-to-done = BURST_LEN + 1 cycles.
- Beat counter: width clog2(BURST_LEN), minimum 1. Never wraps within a transfer; cleared on entry to XFER.
- Only one gnt is ever high. The rvalid/done outputs of the non-owner are always 0.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - When both requests are pending in IDLE, the winner is the requester that did not win the previous arbitration.
  - A last-winner flop is reset to I-cache, so the D-cache wins the first tie.
  - A lone request is always granted.
- Undefined: fixed D-cache priority; the I-cache can starve under continuous D-cache traffic.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n low 3 cycles, then high, no requests.
  - Response: all outputs 0; mem_en stays 0 for 10 cycles.
- I-cache refill:
  - Stimulus: ic_req = 1, ic_addr = 0x0000_0044; mem_ready tied 1; mem_rdata = 0xA0..0xA3.
  - Response: mem_addr sequence 0x40, 0x44, 0x48, 0x4C; ic_rvalid high 4 cycles with those data; ic_done one cycle after the 4th beat.
- D-cache store with wait states:
  - Stimulus: dc_req = 1, dc_we = 1, dc_addr = 0x108, dc_wdata = 0xDEADBEEF; mem_ready asserted after 3 cycles.
  - Response: mem_en, mem_we, addr 0x108 and data held 3 cycles; then dc_done; only one memory beat issued.
- Simultaneous requests:
  - Stimulus: ic_req and dc_req rise in the same cycle.
  - Response: the D-cache is served first. Then the I-cache with a fixed 1-cycle gap, i.e. the I-cache request is granted one IDLE cycle after D-cache done in both builds.
- Round-robin tie (with MEM_ARB_ROUND_ROBIN_EN):
  - Stimulus: both requesters hold requests continuously for 4 transfers.
  - Response: grant order D, I, D, I. Without the macro: D, D, D, D.
- Reset mid-burst:
  - Stimulus: drop rst_n after beat 2 of an I-cache refill.
  - Response: ic_gnt, mem_en and ic_done go 0 immediately with no done pulse; a new request after reset starts at beat 0.
